// File: rtl/ln_norm_scheduler_if.sv
// ln_norm_scheduler_if: requester bus plus linearizer/normalizer chain handshake
interface ln_norm_scheduler_if #(
    parameter int N_REQ = 4,
    parameter int W     = 32,
    parameter int ID_W  = 2
);
    logic [N_REQ-1:0]   req;
    logic [N_REQ*W-1:0] t_in;
    logic [N_REQ-1:0]   done;
    logic [W-1:0]       result_out;
    logic               valid_out;
    logic [ID_W-1:0]    out_id;
    logic               err;
    logic               busy;
    logic [W-1:0]       ln_t;
    logic               ln_rst;
    logic               ln_rst_fsm;
    logic               ln_begin;
    logic               ln_ack;
    logic [W-1:0]       ln_result;

    modport slave (
        input  req, t_in, ln_ack, ln_result,
        output done, result_out, valid_out, out_id, err, busy,
               ln_t, ln_rst, ln_rst_fsm, ln_begin
    );

    modport master (
        output req, t_in, ln_ack, ln_result,
        input  done, result_out, valid_out, out_id, err, busy,
               ln_t, ln_rst, ln_rst_fsm, ln_begin
    );
endinterface

// File: rtl/ln_norm_scheduler.sv
// ln_norm_scheduler: round-robin sharing of one linearizer/normalizer chain with watchdog
module ln_norm_scheduler #(
    parameter int N_REQ   = 4,
    parameter int W       = 32,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 255
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    ln_norm_scheduler_if.slave bus
);
    localparam int TW = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_START, S_WAIT, S_FIN} state_t;

    state_t           r_state;
    logic [ID_W-1:0]  r_ptr;
    logic [ID_W-1:0]  r_out_id;
    logic [W-1:0]     r_ln_t;
    logic [W-1:0]     r_result;
    logic [N_REQ-1:0] r_done;
    logic [TW-1:0]    r_timer;
    logic             r_valid;
    logic             r_err;
    logic             r_busy;
    logic             r_ln_rst_fsm;
    logic             r_ln_begin;
    logic             w_found;
    logic [ID_W-1:0]  w_win;
    logic [ID_W-1:0]  w_ptr_nxt;
    logic [W-1:0]     w_op;

    // first requesting index at or after the pointer; scanning downward lets the nearest one win
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            logic [ID_W-1:0] c;
            c = ID_W'((int'(r_ptr) + j) % N_REQ);
            if (bus.req[c]) begin
                w_found = 1'b1;
                w_win   = c;
            end
        end
    end

    assign w_op      = bus.t_in[int'(w_win) * W +: W];
    assign w_ptr_nxt = (int'(w_win) == N_REQ - 1) ? '0 : w_win + 1'b1;

    // job sequencer: grant, clear chain, start chain, wait for ack or watchdog, report
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_ptr        <= '0;
            r_out_id     <= '0;
            r_ln_t       <= '0;
            r_result     <= '0;
            r_done       <= '0;
            r_timer      <= '0;
            r_valid      <= 1'b0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
            r_ln_rst_fsm <= 1'b0;
            r_ln_begin   <= 1'b0;
        end else begin
            r_ln_rst_fsm <= 1'b0;
            r_ln_begin   <= 1'b0;
            r_valid      <= 1'b0;
            r_done       <= '0;
            r_err        <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_out_id <= w_win;
                        r_ln_t   <= w_op;
                        r_ptr    <= w_ptr_nxt;
                        r_busy   <= 1'b1;
                        r_state  <= S_CLR;
                    end
                end
                S_CLR: begin
                    r_ln_rst_fsm <= 1'b1;
                    r_state      <= S_START;
                end
                S_START: begin
                    r_ln_begin <= 1'b1;
                    r_timer    <= '0;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    r_timer <= r_timer + 1'b1;
                    // timer==0 marks the first WAIT cycle, where a leftover ack is not trusted
                    if (bus.ln_ack && r_timer != '0) begin
                        r_result <= bus.ln_result;
                        r_valid  <= 1'b1;
                        r_done   <= N_REQ'(1) << r_out_id;
                        r_state  <= S_FIN;
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_valid  <= 1'b1;
                        r_done   <= N_REQ'(1) << r_out_id;
                        r_state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.done       = r_done;
    assign bus.result_out = r_result;
    assign bus.valid_out  = r_valid;
    assign bus.out_id     = r_out_id;
    assign bus.err        = r_err;
    assign bus.busy       = r_busy;
    assign bus.ln_t       = r_ln_t;
    assign bus.ln_rst     = !i_rst_n;
    assign bus.ln_rst_fsm = r_ln_rst_fsm;
    assign bus.ln_begin   = r_ln_begin;
endmodule

// File: tb/tb_ln_norm_scheduler.sv
// tb_ln_norm_scheduler: table, hand-written and randomized jobs against a round-robin model
module tb_ln_norm_scheduler;
    localparam int N   = 4;
    localparam int W   = 32;
    localparam int IDW = 2;
    localparam int TO  = 255;
    localparam logic [31:0] SALT = 32'h3F81_0000;

    typedef struct {
        logic [N-1:0] add;
        int           k;
        bit           nev;
        int           id;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [N-1:0] req_r = '0;
    logic [W-1:0] ops [N];
    int           cyc = 0;
    int           n_run = 0;
    int           n_fail = 0;
    int           k_ack = 2;
    bit           never = 1'b0;
    bit           armed = 1'b0;
    int           cnt = 0;
    int           mp = 0;

    always #5 clk = ~clk;

    ln_norm_scheduler_if #(.N_REQ(N), .W(W), .ID_W(IDW)) bus ();

    ln_norm_scheduler #(.N_REQ(N), .W(W), .ID_W(IDW), .TIMEOUT(TO)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    assign bus.req = req_r;
    for (genvar i = 0; i < N; i++) begin : g_tin
        assign bus.t_in[i*W +: W] = ops[i];
    end

    always @(posedge clk) cyc <= cyc + 1;

    // chain stub: ack raised k edges after the Begin edge, held until the FSM reset
    always @(posedge clk) begin
        if (bus.ln_rst) begin
            bus.ln_ack    <= 1'b0;
            bus.ln_result <= '0;
            armed         <= 1'b0;
            cnt           <= 0;
        end else begin
            if (bus.ln_rst_fsm) bus.ln_ack <= 1'b0;
            if (bus.ln_begin) begin
                armed <= !never;
                cnt   <= k_ack - 1;
            end else if (armed) begin
                if (cnt == 1) begin
                    bus.ln_ack    <= 1'b1;
                    bus.ln_result <= bus.ln_t ^ SALT;
                    armed         <= 1'b0;
                end
                cnt <= cnt - 1;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic int rr(input logic [N-1:0] m, input int p);
        for (int j = 0; j < N; j++)
            if (m[(p + j) % N]) return (p + j) % N;
        return -1;
    endfunction

    // one job from an idle negedge: requests added now, checked through DONE and the cycle after
    task automatic job(input logic [N-1:0] add, input int k, input bit nev, input int exp_id,
                       input bit scramble, input bit drop);
        int c0, g, rf_n, rf_at, bg_n, bg_at, v_at;
        bit ln_ok;
        logic [W-1:0] exp_op, exp_res, res;
        logic [N-1:0] dn;
        logic [IDW-1:0] id;
        logic e;
        exp_op = ops[exp_id];
        exp_res = nev ? '0 : exp_op ^ SALT;
        k_ack = k;
        never = nev;
        req_r = req_r | add;
        c0 = cyc;
        g = -1; rf_n = 0; rf_at = -1; bg_n = 0; bg_at = -1; v_at = -1; ln_ok = 1'b1;
        res = '0; dn = '0; id = '0; e = 1'b0;
        for (int c = 0; c < TO + 40 && v_at < 0; c++) begin
            @(negedge clk);
            if (bus.busy && g < 0) g = cyc;
            if (g >= 0 && bus.ln_t !== exp_op) ln_ok = 1'b0;
            if (bus.ln_rst_fsm) begin rf_n++; rf_at = cyc; end
            if (bus.ln_begin) begin bg_n++; bg_at = cyc; end
            if (g >= 0 && cyc == g + 1) begin
                if (scramble) ops[exp_id] = $urandom;
                if (drop) req_r[exp_id] = 1'b0;
            end
            if (bus.valid_out) begin
                v_at = cyc; res = bus.result_out; dn = bus.done; id = bus.out_id; e = bus.err;
            end
        end
        chk("valid_seen", 32'(v_at >= 0), 1);
        chk("grant_cycle", g - c0, 1);
        chk("rst_fsm_pulses", rf_n, 1);
        chk("rst_fsm_at", rf_at - g, 1);
        chk("begin_pulses", bg_n, 1);
        chk("begin_at", bg_at - g, 2);
        chk("valid_at", v_at - g, nev ? 2 + TO : 3 + k);
        chk("out_id", id, exp_id);
        chk("done", dn, 1 << exp_id);
        chk("err", e, nev);
        chk("result", res, exp_res);
        chk("ln_t_stable", ln_ok, 1);
        req_r[exp_id] = 1'b0;
        @(negedge clk);
        chk("busy_drop", bus.busy, 0);
        chk("valid_one_cycle", bus.valid_out, 0);
        chk("done_one_cycle", bus.done, 0);
        chk("result_hold", bus.result_out, exp_res);
        chk("id_hold", bus.out_id, exp_id);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [10];
        int w;
        bit seen;
        tbl[0] = '{4'b0001, 10, 1'b0, 0};
        tbl[1] = '{4'b1111, 4,  1'b0, 1};
        tbl[2] = '{4'b0000, 3,  1'b0, 2};
        tbl[3] = '{4'b0000, 2,  1'b0, 3};
        tbl[4] = '{4'b0000, 7,  1'b0, 0};
        tbl[5] = '{4'b0100, 5,  1'b0, 2};
        tbl[6] = '{4'b0101, 6,  1'b0, 0};
        tbl[7] = '{4'b0000, 3,  1'b0, 2};
        tbl[8] = '{4'b1000, 5,  1'b1, 3};
        tbl[9] = '{4'b0010, 2,  1'b0, 1};
        ops[0] = 32'h3F80_0000;
        ops[1] = 32'h4000_0000;
        ops[2] = 32'h4040_0000;
        ops[3] = 32'h4080_0000;
        #1;
        chk("rst_busy", bus.busy, 0);
        chk("rst_valid", bus.valid_out, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_err", bus.err, 0);
        chk("rst_result", bus.result_out, 0);
        chk("rst_out_id", bus.out_id, 0);
        chk("rst_ln_t", bus.ln_t, 0);
        chk("rst_ln_rst", bus.ln_rst, 1);
        chk("rst_ln_rst_fsm", bus.ln_rst_fsm, 0);
        chk("rst_ln_begin", bus.ln_begin, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rel_ln_rst", bus.ln_rst, 0);
        repeat (3) @(negedge clk);
        chk("idle_no_req", bus.busy, 0);

        for (int i = 0; i < 10; i++) begin
            job(tbl[i].add, tbl[i].k, tbl[i].nev, tbl[i].id, 1'b0, 1'b0);
            mp = (tbl[i].id + 1) % N;
        end

        never = 1'b1;
        req_r = 4'b0011;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge clk);
            seen = bus.ln_begin;
        end
        chk("pre_reset_begin", 32'(seen), 1);
        chk("pre_reset_ln_t", bus.ln_t, ops[rr(req_r, mp)]);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ln_rst", bus.ln_rst, 1);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_result", bus.result_out, 0);
        chk("mid_rst_ln_t", bus.ln_t, 0);
        chk("mid_rst_out_id", bus.out_id, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("mid_rst_no_done", {bus.done, bus.valid_out}, 0);
        end
        rst_n = 1'b1;
        mp = 0;
        job(4'b0000, 5, 1'b0, rr(req_r, mp), 1'b0, 1'b0);
        mp = 1;

        for (int it = 0; it < 40; it++) begin
            logic [N-1:0] m;
            m = req_r | N'($urandom);
            if ($urandom % 4 == 0) m = m & N'($urandom);
            if (m == '0) m = N'(1) << ($urandom % N);
            req_r = m;
            for (int i = 0; i < N; i++) ops[i] = $urandom;
            w = rr(req_r, mp);
            job('0, $urandom_range(2, 20), ($urandom % 16) == 0, w, 1'($urandom), 1'($urandom));
            mp = (w + 1) % N;
        end

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
